// File: rtl/scope_pkg.sv
// Shared types, constants and helpers for the scope acquisition front end.
// Pure declarations: no state, no latency, no flow control.
package scope_pkg;

  localparam int ADC_W       = 12;
  localparam int ROW_W       = 9;
  localparam int SCREEN_ROWS = 300;
  localparam int SCALE_MUL   = 75;
  localparam int SCALE_SHIFT = 10;
  localparam int PROD_W      = 19;

  typedef enum logic [2:0] {
    S_ARMING    = 3'd0,
    S_ARMED     = 3'd1,
    S_CAPTURE   = 3'd2,
    S_WAIT_SWAP = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  // Lower arming threshold for rising triggers, floored at zero.
  function automatic logic [ADC_W-1:0] arm_low(input logic [ADC_W-1:0] level,
                                               input logic [ADC_W-1:0] hyst);
    return (level > hyst) ? level - hyst : '0;
  endfunction

  // Upper arming threshold for falling triggers, clamped at full scale.
  function automatic logic [ADC_W-1:0] arm_high(input logic [ADC_W-1:0] level,
                                                input logic [ADC_W-1:0] hyst);
    logic [ADC_W:0] sum;
    sum = {1'b0, level} + {1'b0, hyst};
    return sum[ADC_W] ? '1 : sum[ADC_W-1:0];
  endfunction

  // Full-scale ADC maps to the top row (0), zero maps to the bottom row.
  function automatic logic [ROW_W-1:0] adc_to_row(input logic [ADC_W-1:0] adc);
    logic [PROD_W-1:0] prod;
    logic [ROW_W-1:0]  scaled;
    prod   = PROD_W'(adc) * PROD_W'(SCALE_MUL);
    scaled = prod[SCALE_SHIFT +: ROW_W];
    return ROW_W'(SCREEN_ROWS - 1) - scaled;
  endfunction

endpackage

// File: rtl/scope_trigger_capture_scaler.sv
// Registered ADC-to-screen-row conversion; 1-cycle latency from take to row_vld.
// No backpressure: every take produces exactly one row_vld strobe.
module scope_scaler
  import scope_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc,
  input  logic             take,
  output logic [ROW_W-1:0] row,
  output logic             row_vld
);

  always_ff @(posedge clk) begin
    if (reset) begin
      row     <= '0;
      row_vld <= 1'b0;
    end else begin
      row_vld <= take;
      if (take) begin
        row <= adc_to_row(adc);
      end
    end
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Decimates ADC samples, arms/fires a hysteretic edge trigger (or auto-timeout) and emits one
// frame of FRAME_LEN screen rows, each 1 cycle after its taken sample; the display paces via full.
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int                FRAME_LEN    = 640,
  parameter logic [ADC_W-1:0]  HYST         = 12'd32,
  parameter logic [19:0]       AUTO_TIMEOUT = 20'd500000,
  parameter logic [15:0]       HOLDOFF      = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] trig,
  input  logic             rising,
  input  logic             auto_en,
  input  logic [7:0]       decim,
  input  logic             full,
  output logic [ROW_W-1:0] sample,
  output logic             valid,
  output logic [2:0]       state_o,
  output logic             triggered
);

  localparam int                CCNT_W   = $clog2(FRAME_LEN);
  localparam logic [CCNT_W-1:0] LAST_COL = CCNT_W'(FRAME_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        dcnt;
  logic [CCNT_W-1:0] ccnt;
  logic [19:0]       tcnt;
  logic [15:0]       hcnt;

  logic              take;
  logic              emit;
  logic              trig_fire;
  logic              far_side;
  logic              crossed;
  logic              auto_hit;
  logic [ADC_W-1:0]  arm_lo;
  logic [ADC_W-1:0]  arm_hi;

  // Decimator: dcnt above a freshly lowered decim just restarts without taking.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt <= '0;
    end else if (adc_valid) begin
      if (dcnt >= decim) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

  always_comb begin
    take     = adc_valid && (dcnt == decim);
    arm_lo   = arm_low(trig, HYST);
    arm_hi   = arm_high(trig, HYST);
    far_side = rising ? (adc_data < arm_lo) : (adc_data > arm_hi);
    crossed  = rising ? (adc_data >= trig) : (adc_data <= trig);
    auto_hit = auto_en && (tcnt >= AUTO_TIMEOUT - 20'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_ARMING;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    trig_fire = 1'b0;
    case (state)
      S_ARMING: begin
        if (take && far_side) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // A real crossing wins over a simultaneous timeout, so the pulse still fires.
        if (take && (crossed || auto_hit)) begin
          state_nxt = S_CAPTURE;
          emit      = 1'b1;
          trig_fire = crossed;
        end
      end
      S_CAPTURE: begin
        if (take) begin
          emit = 1'b1;
          if (ccnt == LAST_COL) begin
            state_nxt = S_WAIT_SWAP;
          end
        end
      end
      S_WAIT_SWAP: begin
        // Ignore full while the last point is still on the bus.
        if (full && !valid) begin
          state_nxt = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (hcnt == HOLDOFF - 16'd1) begin
          state_nxt = S_ARMING;
        end
      end
      default: begin
        state_nxt = S_ARMING;
      end
    endcase
  end

  // Column counter; the triggering sample is column 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ccnt <= '0;
    end else if (emit) begin
      ccnt <= (state_nxt == S_WAIT_SWAP) ? '0 : ccnt + 1'b1;
    end else if (state != S_CAPTURE) begin
      ccnt <= '0;
    end
  end

  // Timeout counter restarts every time ARMED is entered and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state != S_ARMED) begin
      tcnt <= '0;
    end else if (take && (tcnt != '1)) begin
      tcnt <= tcnt + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
    end else if (state == S_HOLDOFF) begin
      hcnt <= hcnt + 16'd1;
    end else begin
      hcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      triggered <= 1'b0;
    end else begin
      triggered <= trig_fire;
    end
  end

  scope_scaler u_scaler (
    .clk     (clk),
    .reset   (reset),
    .adc     (adc_data),
    .take    (emit),
    .row     (sample),
    .row_vld (valid)
  );

  assign state_o = state;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: stimulus pushes expected rows, a monitor pops
// and compares on every valid strobe.
module tb_scope_trigger_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] trig;
  logic        rising;
  logic        auto_en;
  logic [7:0]  decim;
  logic        full;
  logic [8:0]  sample;
  logic        valid;
  logic [2:0]  state_o;
  logic        triggered;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          vcount = 0;
  bit          chk_gap = 1'b0;
  bit          have_last = 1'b0;
  int          last_cyc = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_e;

  scope_trigger_capture #(.AUTO_TIMEOUT(20'd10)) dut (
    .clk       (clk),
    .reset     (reset),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .trig      (trig),
    .rising    (rising),
    .auto_en   (auto_en),
    .decim     (decim),
    .full      (full),
    .sample    (sample),
    .valid     (valid),
    .state_o   (state_o),
    .triggered (triggered)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] row_of(input int a);
    return 9'(299 - ((a * 75) >> 10));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input bit v);
    adc_data  = 12'(a);
    adc_valid = v;
    tick();
  endtask

  task automatic push(input int a, input bit t);
    exp_q.push_back({t, row_of(a)});
  endtask

  task automatic mon_step();
    if (valid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid sample=%0d expected no strobe", sample);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample", int'(sample), int'(mon_e[8:0]));
        check("triggered", int'(triggered), int'(mon_e[9]));
      end
      if (chk_gap) begin
        if (have_last) check("strobe_gap", cyc - last_cyc, 4);
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end else if (triggered) begin
      checks++;
      errors++;
      $display("FAIL stray_triggered triggered=1 expected 0 without valid");
    end
  endtask

  task automatic end_frame(input string tag);
    drive(0, 0);
    drive(0, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_strobes"}, vcount, 640);
    check({tag, "_wait_swap"}, int'(state_o), 3);
  endtask

  task automatic swap_and_rearm(input string tag);
    int n;
    full = 1'b1;
    tick();
    full = 1'b0;
    n = 0;
    while (state_o == 3'd4 && n < 2000) begin
      n++;
      tick();
    end
    check({tag, "_holdoff_cycles"}, n, 1000);
    check({tag, "_rearmed"}, int'(state_o), 0);
  endtask

  // Ramp step 16 wrapping at 4096; arms on adc=0, fires at adc=2048 (index 128).
  task automatic run_ramp(input string tag);
    int a;
    vcount = 0;
    rising = 1'b1;
    trig   = 12'd2048;
    for (int i = 0; i < 128 + 640 + 20; i++) begin
      a = (16 * i) % 4096;
      if (i >= 128 && i < 768) push(a, i == 128);
      drive(a, 1);
    end
    end_frame(tag);
  endtask

  initial begin
    int a;
    int p;
    int g;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    reset = 1'b1; adc_data = '0; adc_valid = 1'b0; trig = 12'd2048;
    rising = 1'b1; auto_en = 1'b0; decim = 8'd0; full = 1'b0;
    tick();
    tick();
    check("reset_state", int'(state_o), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_sample", int'(sample), 0);
    check("reset_triggered", int'(triggered), 0);
    reset = 1'b0;

    run_ramp("ramp");

    for (int i = 0; i < 5000; i++) tick();
    check("swap_hold_state", int'(state_o), 3);
    swap_and_rearm("ramp");

    // Falling trigger at 1000: dither inside the hysteresis band must not arm.
    rising = 1'b0;
    trig   = 12'd1000;
    for (int i = 0; i < 150; i++) drive(1000 + ((i % 3) - 1) * 8, 1);
    check("dither_no_arm", int'(state_o), 0);
    vcount = 0;
    // Triangle 900..1200 step 20: arms at 1040, fires on the way down at 1000 (index 25).
    for (int i = 0; i < 25 + 640 + 10; i++) begin
      p = i % 30;
      a = (p <= 15) ? 900 + 20 * p : 900 + 20 * (30 - p);
      if (i >= 25 && i < 665) push(a, i == 25);
      drive(a, 1);
    end
    end_frame("falling");
    swap_and_rearm("falling");

    // decim=3 from a clean decimator: taken on every 4th valid.
    reset = 1'b1;
    adc_valid = 1'b0;
    tick();
    reset = 1'b0;
    decim = 8'd3;
    rising = 1'b1;
    trig = 12'd2048;
    vcount = 0;
    chk_gap = 1'b1;
    have_last = 1'b0;
    for (int c = 0; c < 4 * 642; c++) begin
      g = c / 4;
      a = (g == 0) ? 0 : ((g % 2 == 1) ? 4095 : 0);
      if (c % 4 == 3 && g >= 1 && g <= 640) push(a, g == 1);
      drive(a, 1);
    end
    chk_gap = 1'b0;
    end_frame("decim");
    decim = 8'd0;
    swap_and_rearm("decim");

    // Auto path: arms on 0, 10th taken sample in ARMED (adc=640) becomes column 0.
    auto_en = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10 + 640 + 10; i++) begin
      a = (64 * i) % 4096;
      if (i >= 10 && i < 650) push(a, 1'b0);
      drive(a, 1);
    end
    end_frame("auto");
    swap_and_rearm("auto");

    auto_en = 1'b0;
    for (int i = 0; i < 100; i++) drive(0, 1);
    check("no_auto_capture", int'(state_o), 1);

    // Abort mid-frame: reset while column 300 is on the bus.
    vcount = 0;
    for (int k = 0; k <= 300; k++) begin
      push(4095, k == 0);
      drive(4095, 1);
    end
    reset = 1'b1;
    tick();
    check("abort_valid", int'(valid), 0);
    check("abort_state", int'(state_o), 0);
    check("abort_strobes", vcount, 301);
    check("abort_drained", exp_q.size(), 0);
    reset = 1'b0;
    drive(0, 0);

    run_ramp("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Upstream acquisition stage for the VGA scope display.
- Takes raw 12-bit ADC samples, decimates them and detects a level/edge trigger with hysteresis.
- After a trigger (or auto-timeout) it emits one frame of exactly FRAME_LEN screen-scaled 9-bit samples on sample/valid into the display's ping-pong buffers.
- Uses the display's full flag to pace frames, then holds off before re-arming.

Parameters:
- FRAME_LEN, 640, samples per captured frame; one per display column.
- HYST, 12'd32, trigger hysteresis in ADC LSBs.
- AUTO_TIMEOUT, 20'd500000, decimated samples waited in ARMED before forcing a capture when auto_en=1.
- HOLDOFF, 16'd1000, clk cycles in HOLDOFF before re-arming.

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous active-high reset.
- adc_data, input, 12, unsigned ADC sample.
- adc_valid, input, 1, adc_data is valid this cycle.
- trig, input, 12, trigger level in ADC units.
- rising, input, 1, 1 = rising-edge trigger, 0 = falling-edge trigger.
- auto_en, input, 1, enable auto-trigger on timeout.
- decim, input, 8, keep one of every decim+1 accepted ADC samples.
- full, input, 1, display frame-complete/buffer-swap flag.
- sample, output, 9, screen row of the emitted point (0 = top).
- valid, output, 1, one-cycle strobe qualifying sample.
- state_o, output, 3, current FSM state, for debug.
- triggered, output, 1, one-cycle pulse when a real (non-auto) trigger fires.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=ARMING; sample=0, valid=0, triggered=0.
  - All counters and prev-sample register cleared.
  - Reset mid-capture aborts the frame immediately; no further valid.
- Decimator:
  - dcnt counts adc_valid cycles 0..decim; a sample is "taken" when adc_valid=1 and dcnt==decim, then dcnt wraps to 0.
  - decim=0 takes every adc_valid.
  - A decim change takes effect at the next wrap; if dcnt>decim after the change, dcnt resets to 0 on the next adc_valid.
- Scaling: row = 299 - ((adc_data*75) >> 10).
  - 19-bit intermediate product; result range 0..299 (4095 -> 0, 0 -> 299).
  - Registered; 1-cycle latency from taken sample to sample/valid.
- FSM states (state_o encoding in parentheses):
  - ARMING (0): wait for a taken sample on the "far" side of the level. For rising: adc < trig-HYST (saturate at 0). For falling: adc > trig+HYST (saturate at 4095). Then go to ARMED.
  - ARMED (1): trigger when a taken sample crosses the level; rising: adc >= trig; falling: adc <= trig. On trigger: pulse triggered, go to CAPTURE. The triggering sample is column 0.
  - ARMED auto path: if auto_en=1 and the timeout counter reaches AUTO_TIMEOUT taken samples, go to CAPTURE with no triggered pulse. That sample is column 0.
  - CAPTURE (2): each taken sample emits valid one cycle later. ccnt counts 0..FRAME_LEN-1. After emitting column FRAME_LEN-1, go to WAIT_SWAP.
  - WAIT_SWAP (3): wait for full==1 sampled on a cycle at least 1 cycle after the last valid; then go to HOLDOFF.
  - HOLDOFF (4): count HOLDOFF clk cycles, then go to ARMING.
- Timeout counter clears on entry to ARMED.
- valid is never asserted outside CAPTURE, so valid count per frame is exactly FRAME_LEN.
- trig/rising/auto_en are sampled continuously. A change during CAPTURE does not affect the current frame.
- Simultaneous trigger and timeout on the same sample: the real trigger wins (triggered pulses).
- adc_valid gaps: the FSM holds state; valid only follows taken samples.

Decomposition:
- Package scope_pkg:
  - state enum: ARMING, ARMED, CAPTURE, WAIT_SWAP, HOLDOFF.
  - Constants: SCREEN_ROWS=300, SCALE_MUL=75, SCALE_SHIFT=10, ADC_W=12, ROW_W=9.
- Sub-module scope_scaler: registered ADC-to-row conversion, 1-cycle latency.
- The FSM and decimator stay in the top module.

Test Plan:
- Reset, decim=0, rising=1, trig=2048, ramp 0->4095 step 16 every cycle -> triggered pulses on adc=2048; first sample=299-((2048*75)>>10)=149; exactly 640 valid strobes follow, then no more valid.
- rising=0, trig=1000, triangle wave -> trigger only on the falling crossing at adc<=1000, after the signal first exceeded 1032; a noisy ±8 LSB dither around 1000 without exceeding 1032 gives no trigger.
- decim=3, constant adc_valid -> valid strobes exactly every 4 cycles; adc=0 -> sample=299; adc=4095 -> sample=0.
- auto_en=1, constant adc=0, AUTO_TIMEOUT overridden to 10 -> capture starts on the 10th taken sample in ARMED with no triggered pulse; auto_en=0 -> no capture ever.
- After a frame, hold full=0 for 5000 cycles -> state stays WAIT_SWAP; raise full -> HOLDOFF for exactly HOLDOFF cycles, then ARMING.
- Assert reset at column 300 of CAPTURE -> valid=0 from the next cycle, state_o=0, and the next frame again has exactly 640 strobes.
